// File: rtl/multicycle_sequencer_pkg.sv
// ============================================================================
// seq_pkg: states, opcode classes and fault codes for multicycle_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_IMEM_TO = 2'd2;
    localparam logic [1:0] FC_DMEM_TO = 2'd3;

    function automatic logic opcode_legal(input logic [6:0] opc);
        return (opc == OPC_LOAD)  || (opc == OPC_STORE) || (opc == OPC_OP) ||
               (opc == OPC_OPIMM) || (opc == OPC_BRANCH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_sequencer_req_timeout.sv
// ============================================================================
// req_timeout: memory request wait counter with expiry flag
// Rev 1.0
// ============================================================================
`default_nettype none

module req_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // count_en already excludes an ack, so an ack on the last cycle wins
    assign expired = count_en && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB timing, retire count, traps
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      instr,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instret
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] code_nxt;
    logic [6:0] opc;
    logic       wait_count;
    logic       wait_clear;
    logic       wait_expired;
    logic       unused_instr;

    assign opc          = instr[6:0];
    assign unused_instr = ^instr[31:7];

    assign wait_count = ((state == ST_FETCH) && !imem_ack) ||
                        ((state == ST_MEM)   && !dmem_ack);
    assign wait_clear = !wait_count;

    req_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_req_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .count_en (wait_count),
        .expired  (wait_expired)
    );

    always_comb begin
        state_nxt = state;
        code_nxt  = fault_code;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (wait_expired) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (!opcode_legal(opc)) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_ILLEGAL;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opc == OPC_BRANCH) begin
                    pc_we     = 1'b1;
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                end else if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OPC_STORE);
                if (dmem_ack) begin
                    if (opc == OPC_STORE) begin
                        pc_we     = 1'b1;
                        state_nxt = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_DMEM_TO;
                end
            end
            ST_WB: begin
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            instret    <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
            fault      <= (state_nxt == ST_FAULT);
            fault_code <= code_nxt;
            if (pc_we) instret <= instret + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A283;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    // {imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, busy}
    localparam logic [6:0] S_IDLE   = 7'b0000000;
    localparam logic [6:0] S_FA     = 7'b1100001;
    localparam logic [6:0] S_FW     = 7'b1000001;
    localparam logic [6:0] S_BUSY   = 7'b0000001;
    localparam logic [6:0] S_MEMRD  = 7'b0010001;
    localparam logic [6:0] S_MEMWR  = 7'b0011101;
    localparam logic [6:0] S_BRRET  = 7'b0000101;
    localparam logic [6:0] S_WB     = 7'b0000111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [31:0]      instr;
    logic             imem_req;
    logic             imem_ack;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             ir_we;
    logic             pc_we;
    logic             reg_we;
    logic             busy;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] instret;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .instr      (instr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .instret    (instret)
    );

    function automatic logic [6:0] strobes();
        return {imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, busy};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (strobes() !== S_IDLE) $display("FAIL reset_strobes got=%b exp=%b", strobes(), S_IDLE); else passed++;
        total++; if ({fault, fault_code} !== 3'b000) $display("FAIL reset_fault got=%b exp=000", {fault, fault_code}); else passed++;
        total++; if (instret !== 3'd0) $display("FAIL reset_instret got=%0d exp=0", instret); else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        instr = I_ADD; run = 1'b1; #1;
        total++; if (strobes() !== S_IDLE) $display("FAIL add_idle got=%b exp=%b", strobes(), S_IDLE); else passed++;
        @(negedge clk); imem_ack = 1'b1; #1;
        total++; if (strobes() !== S_FA) $display("FAIL add_fetch got=%b exp=%b", strobes(), S_FA); else passed++;
        @(negedge clk); imem_ack = 1'b0; #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL add_decode got=%b exp=%b", strobes(), S_BUSY); else passed++;
        @(negedge clk); #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL add_exec got=%b exp=%b", strobes(), S_BUSY); else passed++;
        @(negedge clk); run = 1'b0; #1;
        total++; if (strobes() !== S_WB) $display("FAIL add_wb got=%b exp=%b", strobes(), S_WB); else passed++;
        @(negedge clk); #1;
        total++; if (instret !== 3'd1) $display("FAIL add_instret got=%0d exp=1", instret); else passed++;
        total++; if (strobes() !== S_IDLE) $display("FAIL add_to_idle got=%b exp=%b", strobes(), S_IDLE); else passed++;
    endtask

    task automatic test_load_wait();
        instr = I_LW; run = 1'b1;
        @(negedge clk); imem_ack = 1'b1; #1;
        total++; if (strobes() !== S_FA) $display("FAIL lw_fetch got=%b exp=%b", strobes(), S_FA); else passed++;
        @(negedge clk); imem_ack = 1'b0; #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL lw_decode got=%b exp=%b", strobes(), S_BUSY); else passed++;
        @(negedge clk); #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL lw_exec got=%b exp=%b", strobes(), S_BUSY); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dmem_ack = (i == 3); #1;
            total++; if (strobes() !== S_MEMRD) $display("FAIL lw_mem%0d got=%b exp=%b", i, strobes(), S_MEMRD); else passed++;
        end
        @(negedge clk); dmem_ack = 1'b0; run = 1'b0; #1;
        total++; if (strobes() !== S_WB) $display("FAIL lw_wb got=%b exp=%b", strobes(), S_WB); else passed++;
        @(negedge clk); #1;
        total++; if (instret !== 3'd2) $display("FAIL lw_instret got=%0d exp=2", instret); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL lw_no_fault got=%b exp=0", fault); else passed++;
    endtask

    task automatic test_store_branch();
        instr = I_SW; run = 1'b1;
        @(negedge clk); imem_ack = 1'b1; #1;
        total++; if (strobes() !== S_FA) $display("FAIL sw_fetch got=%b exp=%b", strobes(), S_FA); else passed++;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL sw_exec got=%b exp=%b", strobes(), S_BUSY); else passed++;
        @(negedge clk); dmem_ack = 1'b1; #1;
        total++; if (strobes() !== S_MEMWR) $display("FAIL sw_mem got=%b exp=%b", strobes(), S_MEMWR); else passed++;
        @(negedge clk); dmem_ack = 1'b0; instr = I_BEQ; imem_ack = 1'b1; #1;
        total++; if (strobes() !== S_FA) $display("FAIL beq_b2b_fetch got=%b exp=%b", strobes(), S_FA); else passed++;
        @(negedge clk); imem_ack = 1'b0; #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL beq_decode got=%b exp=%b", strobes(), S_BUSY); else passed++;
        @(negedge clk); run = 1'b0; #1;
        total++; if (strobes() !== S_BRRET) $display("FAIL beq_exec got=%b exp=%b", strobes(), S_BRRET); else passed++;
        @(negedge clk); #1;
        total++; if (instret !== 3'd4) $display("FAIL sb_instret got=%0d exp=4", instret); else passed++;
        total++; if (strobes() !== S_IDLE) $display("FAIL sb_idle got=%b exp=%b", strobes(), S_IDLE); else passed++;
    endtask

    task automatic test_run_drop();
        instr = I_ADD; run = 1'b1;
        @(negedge clk); imem_ack = 1'b1; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); run = 1'b0; #1;
        total++; if (strobes() !== S_BUSY) $display("FAIL drop_exec got=%b exp=%b", strobes(), S_BUSY); else passed++;
        @(negedge clk); #1;
        total++; if (strobes() !== S_WB) $display("FAIL drop_wb got=%b exp=%b", strobes(), S_WB); else passed++;
        @(negedge clk); #1;
        total++; if (strobes() !== S_IDLE) $display("FAIL drop_idle got=%b exp=%b", strobes(), S_IDLE); else passed++;
        total++; if (instret !== 3'd5) $display("FAIL drop_instret got=%0d exp=5", instret); else passed++;
        @(negedge clk); #1;
        total++; if (strobes() !== S_IDLE) $display("FAIL drop_stay got=%b exp=%b", strobes(), S_IDLE); else passed++;
    endtask

    task automatic test_fetch_late_ack();
        instr = I_ADD; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); imem_ack = (i == 3); #1;
            total++; if (strobes() !== ((i == 3) ? S_FA : S_FW)) $display("FAIL late_fetch%0d got=%b exp=%b", i, strobes(), (i == 3) ? S_FA : S_FW); else passed++;
        end
        @(negedge clk); imem_ack = 1'b0; #1;
        total++; if ({fault, strobes()} !== {1'b0, S_BUSY}) $display("FAIL late_decode got=%b exp=%b", {fault, strobes()}, {1'b0, S_BUSY}); else passed++;
        @(negedge clk); #1;
        @(negedge clk); run = 1'b0; #1;
        total++; if (strobes() !== S_WB) $display("FAIL late_wb got=%b exp=%b", strobes(), S_WB); else passed++;
        @(negedge clk); #1;
        total++; if (instret !== 3'd6) $display("FAIL late_instret got=%0d exp=6", instret); else passed++;
    endtask

    task automatic test_illegal();
        instr = I_BAD; run = 1'b1;
        @(negedge clk); imem_ack = 1'b1; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        total++; if ({fault, strobes()} !== {1'b0, S_BUSY}) $display("FAIL ill_decode got=%b exp=%b", {fault, strobes()}, {1'b0, S_BUSY}); else passed++;
        @(negedge clk); #1;
        total++; if (strobes() !== S_IDLE) $display("FAIL ill_strobes got=%b exp=%b", strobes(), S_IDLE); else passed++;
        total++; if ({fault, fault_code} !== 3'b101) $display("FAIL ill_fault got=%b exp=101", {fault, fault_code}); else passed++;
        @(negedge clk); #1;
        total++; if ({fault, fault_code, strobes()} !== {3'b101, S_IDLE}) $display("FAIL ill_sticky got=%b exp=%b", {fault, fault_code, strobes()}, {3'b101, S_IDLE}); else passed++;
        total++; if (instret !== 3'd6) $display("FAIL ill_instret got=%0d exp=6", instret); else passed++;
        rst_n = 1'b0; run = 1'b0; #1;
        total++; if ({fault, fault_code, instret} !== 6'd0) $display("FAIL ill_reset got=%b exp=000000", {fault, fault_code, instret}); else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_imem_timeout();
        instr = I_ADD; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++; if (strobes() !== S_FW) $display("FAIL ito_wait%0d got=%b exp=%b", i, strobes(), S_FW); else passed++;
        end
        @(negedge clk); #1;
        total++; if ({fault, fault_code, strobes()} !== {3'b110, S_IDLE}) $display("FAIL ito_fault got=%b exp=%b", {fault, fault_code, strobes()}, {3'b110, S_IDLE}); else passed++;
        rst_n = 1'b0; run = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_dmem_timeout();
        instr = I_LW; run = 1'b1;
        @(negedge clk); imem_ack = 1'b1; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++; if (strobes() !== S_MEMRD) $display("FAIL dto_wait%0d got=%b exp=%b", i, strobes(), S_MEMRD); else passed++;
        end
        @(negedge clk); #1;
        total++; if ({fault, fault_code, strobes()} !== {3'b111, S_IDLE}) $display("FAIL dto_fault got=%b exp=%b", {fault, fault_code, strobes()}, {3'b111, S_IDLE}); else passed++;
        rst_n = 1'b0; run = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        instr = I_SW; run = 1'b1;
        @(negedge clk); imem_ack = 1'b1; #1;
        @(negedge clk); imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++; if (strobes() !== 7'b0011001) $display("FAIL ar_mem got=%b exp=0011001", strobes()); else passed++;
        #1 rst_n = 1'b0; run = 1'b0; #1;
        total++; if ({dmem_req, dmem_we, busy} !== 3'b000) $display("FAIL ar_drop got=%b exp=000", {dmem_req, dmem_we, busy}); else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_back_to_back_wrap();
        instr = I_BEQ; run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); imem_ack = 1'b1; #1;
            total++; if (strobes() !== S_FA) $display("FAIL b2b_fetch%0d got=%b exp=%b", k, strobes(), S_FA); else passed++;
            @(negedge clk); imem_ack = 1'b0; #1;
            @(negedge clk); if (k == 7) run = 1'b0; #1;
            total++; if ({instret, strobes()} !== {3'(k), S_BRRET}) $display("FAIL b2b_exec%0d got=%b exp=%b", k, {instret, strobes()}, {3'(k), S_BRRET}); else passed++;
        end
        @(negedge clk); #1;
        total++; if (instret !== 3'd0) $display("FAIL wrap_instret got=%0d exp=0", instret); else passed++;
        total++; if (strobes() !== S_IDLE) $display("FAIL wrap_idle got=%b exp=%b", strobes(), S_IDLE); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store_branch();
        test_run_drop();
        test_fetch_late_ack();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_async_reset();
        test_back_to_back_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
